// File: rtl/store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// store_buffer_pkg
// Shared types and constants for the store buffer.
//   WORD_LSB   : number of byte-offset bits below the word index
//   SB_W       : address/data width that the entry type is built for; the
//                store_buffer WIDTH parameter is expected to equal it
//   sb_entry_t : one buffer entry {valid, word address, data}
//   sb_ptr_w() : pointer width for a DEPTH-entry ring
// -----------------------------------------------------------------------------
package store_buffer_pkg;

   localparam int WORD_LSB = 2;
   localparam int SB_W     = 32;

   typedef struct packed {
      logic                     valid;
      logic [SB_W-1:WORD_LSB]   waddr;
      logic [SB_W-1:0]          data;
   } sb_entry_t;

   function automatic int sb_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/store_buf_match.sv
// -----------------------------------------------------------------------------
// store_buf_match
// Combinational youngest-match search over the store buffer entries.
// Ports:
//   i_ent   : entry array (valid, word address, data)
//   i_head  : index of the oldest entry
//   i_waddr : word address to look up
//   o_hit   : some valid entry holds i_waddr
//   o_data  : data of the youngest matching entry (0 when no hit)
// -----------------------------------------------------------------------------
module store_buf_match
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  sb_entry_t                 i_ent [DEPTH],
   input  logic [PTR_W-1:0]          i_head,
   input  logic [SB_W-1:WORD_LSB]    i_waddr,
   output logic                      o_hit,
   output logic [SB_W-1:0]           o_data
);

   logic [PTR_W-1:0] w_idx;

   // Walk from oldest to youngest; a later match overwrites an earlier one,
   // so the entry nearest the tail wins. Pointer arithmetic wraps because
   // DEPTH is a power of two.
   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      w_idx  = i_head;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = i_head + PTR_W'(i);
         if (i_ent[w_idx].valid && (i_ent[w_idx].waddr == i_waddr)) begin
            o_hit  = 1'b1;
            o_data = i_ent[w_idx].data;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// Write buffer between the core memory stage and data memory. Stores enter a
// DEPTH-entry FIFO in one cycle and drain to memory whenever no load uses the
// port and memory is ready. Loads go straight to memory.
//
// Build option STORE_BUF_FWD_EN:
//   defined   : a load hitting a buffered word is forwarded the youngest data.
//   undefined : a load hitting a buffered word stalls; the buffer drains
//               (ignoring the load) until no match remains, then the load
//               reads memory.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   st_req, ld_req      : core store / load request (never both high)
//   fence_req           : core waits until the buffer is empty
//   addr, wdata         : core byte address and store data
//   rdata               : load data to core
//   stall_o             : core must hold its memory-stage request
//   mem_we/addr/wdata   : memory write port (mem_addr also carries load addr)
//   mem_rdata           : memory combinational read data
//   mem_ready           : memory accepts a write this cycle
//   empty_o             : buffer holds no entries
// -----------------------------------------------------------------------------
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              st_req,
   input  logic              ld_req,
   input  logic              fence_req,
   input  logic [WIDTH-1:0]  addr,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata,
   output logic              stall_o,
   output logic              mem_we,
   output logic [WIDTH-1:0]  mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic [WIDTH-1:0]  mem_rdata,
   input  logic              mem_ready,
   output logic              empty_o
);

   localparam int PTR_W = sb_ptr_w(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Control state (reset) and entry payload (not reset).
   logic [PTR_W-1:0]          r_head;
   logic [PTR_W-1:0]          r_tail;
   logic [CNT_W-1:0]          r_count;
   logic [DEPTH-1:0]          r_valid;
   logic [WIDTH-1:WORD_LSB]   r_waddr [DEPTH];
   logic [WIDTH-1:0]          r_data  [DEPTH];

   sb_entry_t                 w_ent [DEPTH];
   logic                      w_empty;
   logic                      w_full;
   logic                      w_hit;
   logic [WIDTH-1:0]          w_hit_data;
   logic                      w_fwd_stall;
   logic                      w_drain;
   logic                      w_enq;
   logic                      w_stall;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_ent[i].valid = r_valid[i];
         w_ent[i].waddr = r_waddr[i];
         w_ent[i].data  = r_data[i];
      end
   end

   store_buf_match #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_match (
      .i_ent   (w_ent),
      .i_head  (r_head),
      .i_waddr (addr[WIDTH-1:WORD_LSB]),
      .o_hit   (w_hit),
      .o_data  (w_hit_data)
   );

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(DEPTH));

`ifdef STORE_BUF_FWD_EN
   assign w_fwd_stall = 1'b0;
   assign w_drain     = !w_empty && !ld_req && mem_ready;
`else
   // A matching load must wait, so it gives the port to the buffer until
   // its word has been written out.
   assign w_fwd_stall = ld_req && w_hit;
   assign w_drain     = !w_empty && (!ld_req || w_fwd_stall) && mem_ready;
`endif

   // A full buffer still accepts a store in a cycle that frees a slot.
   assign w_stall = (st_req && w_full && !w_drain)
                  || (fence_req && !w_empty)
                  || w_fwd_stall;
   assign w_enq   = st_req && !w_stall;

   assign stall_o   = w_stall;
   assign empty_o   = w_empty;
   assign mem_we    = w_drain;
   assign mem_addr  = w_drain ? {r_waddr[r_head], {WORD_LSB{1'b0}}} : addr;
   assign mem_wdata = w_drain ? r_data[r_head] : '0;
   // Without forwarding a hit always stalls the load, so the forwarded value
   // is never consumed in that build.
   assign rdata     = w_hit ? w_hit_data : mem_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else begin
         // Clear before set: when full, drain and enqueue hit the same slot.
         if (w_drain) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + 1'b1;
         end
         if (w_enq) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + 1'b1;
         end
         case ({w_enq, w_drain})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_waddr[r_tail] <= addr[WIDTH-1:WORD_LSB];
         r_data[r_tail]  <= wdata;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

   localparam int W = 32;
   localparam int D = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          st_req, ld_req, fence_req;
   logic [W-1:0]  addr, wdata;
   logic [W-1:0]  rdata;
   logic          stall_o, mem_we, empty_o;
   logic [W-1:0]  mem_addr, mem_wdata, mem_rdata;
   logic          mem_ready;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] d;
   } ent_t;

   ent_t         q[$];
   logic [W-1:0] memarr [0:1023];

   store_buffer #(.WIDTH(W), .DEPTH(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .st_req    (st_req),
      .ld_req    (ld_req),
      .fence_req (fence_req),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .stall_o   (stall_o),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .empty_o   (empty_o)
   );

   always #5 clk = ~clk;

   // Data memory: combinational read, write on the edge when mem_we is high.
   initial begin
      for (int i = 0; i < 1024; i++) memarr[i] = 32'hC0DE_0000 | i;
   end
   always @(posedge clk) if (mem_we === 1'b1) memarr[mem_addr[11:2]] <= mem_wdata;
   assign mem_rdata = memarr[mem_addr[11:2]];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
      end
   endtask

   // Behavioural model: the buffer is a queue of pending stores, oldest first.
   always @(negedge clk) begin
      int           n;
      logic         hit, fst, drn, stl;
      logic [W-1:0] hd;
      if (rst) begin
         q.delete();
         chk("rst_empty", {31'd0, empty_o}, 1);
         chk("rst_mem_we", {31'd0, mem_we}, 0);
         chk("rst_stall", {31'd0, stall_o}, 0);
      end else begin
         n   = q.size();
         hit = 1'b0;
         hd  = '0;
         for (int i = 0; i < n; i++)
            if (q[i].a[W-1:2] == addr[W-1:2]) begin
               hit = 1'b1;
               hd  = q[i].d;
            end
`ifdef STORE_BUF_FWD_EN
         fst = 1'b0;
         drn = (n > 0) && !ld_req && mem_ready;
`else
         fst = ld_req && hit;
         drn = (n > 0) && (!ld_req || fst) && mem_ready;
`endif
         stl = (st_req && (n == D) && !drn) || (fence_req && (n > 0)) || fst;
         chk("m_empty", {31'd0, empty_o}, {31'd0, (n == 0)});
         chk("m_stall", {31'd0, stall_o}, {31'd0, stl});
         chk("m_mem_we", {31'd0, mem_we}, {31'd0, drn});
         if (drn) begin
            chk("m_mem_addr", mem_addr, {q[0].a[W-1:2], 2'b00});
            chk("m_mem_wdata", mem_wdata, q[0].d);
         end else begin
            chk("m_mem_addr_ld", mem_addr, addr);
            chk("m_mem_wdata_idle", mem_wdata, 0);
         end
         if (ld_req && !stl)
            chk("m_rdata", rdata, hit ? hd : memarr[addr[11:2]]);
         if (drn) void'(q.pop_front());
         if (st_req && !stl) q.push_back('{a: addr, d: wdata});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [W-1:0] a, input logic [W-1:0] d);
      st_req = 1'b1; ld_req = 1'b0; addr = a; wdata = d;
      cyc();
      st_req = 1'b0;
   endtask

   task automatic wait_empty(input string nm);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (empty_o) begin ok = 1'b1; break; end
      end
      chk(nm, {31'd0, ok}, 1);
      cyc();
   endtask

   // Load of a word that is sitting in the buffer, memory not ready.
   task automatic load_check(input string nm, input logic [W-1:0] a, input logic [W-1:0] exp);
      logic ok;
      st_req = 1'b0; ld_req = 1'b1; addr = a; mem_ready = 1'b0;
      @(negedge clk);
`ifdef STORE_BUF_FWD_EN
      chk({nm, "_rdata"}, rdata, exp);
      chk({nm, "_nostall"}, {31'd0, stall_o}, 0);
      cyc();
      ld_req = 1'b0;
      mem_ready = 1'b1;
`else
      chk({nm, "_stall"}, {31'd0, stall_o}, 1);
      cyc();
      mem_ready = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (!stall_o) begin ok = 1'b1; break; end
      end
      chk({nm, "_release"}, {31'd0, ok}, 1);
      chk({nm, "_rdata"}, rdata, exp);
      cyc();
      ld_req = 1'b0;
`endif
      wait_empty({nm, "_drained"});
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; st_req = 1'b0; ld_req = 1'b0; fence_req = 1'b0;
      addr = '0; wdata = '0; mem_ready = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      cyc();

      // Test 1: reset while draining with entries pending.
      store(32'h10, 32'h11); store(32'h14, 32'h12);
      store(32'h18, 32'h13); store(32'h1C, 32'h14);
      mem_ready = 1'b1;
      cyc();
      rst = 1'b1;
      #1;
      chk("t1_empty_now", {31'd0, empty_o}, 1);
      chk("t1_we_now", {31'd0, mem_we}, 0);
      cyc(); cyc();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t1_no_write", {31'd0, mem_we}, 0);
      end
      chk("t1_mem_untouched", memarr[32'h18 >> 2], 32'hC0DE_0006);
      cyc();

      // Test 2: store then load of the same word.
      mem_ready = 1'b0;
      store(32'h100, 32'hAAAA_0001);
      load_check("t2", 32'h100, 32'hAAAA_0001);

      // Test 3: youngest of two matching stores wins.
      mem_ready = 1'b0;
      store(32'h200, 32'h1);
      store(32'h200, 32'h2);
      load_check("t3", 32'h200, 32'h2);
      chk("t3_mem", memarr[32'h200 >> 2], 32'h2);

      // Test 4: full buffer stalls the fifth store until a drain frees a slot.
      mem_ready = 1'b0;
      for (int k = 0; k < 4; k++) store(32'h400 + 4 * k, 32'h40 + k);
      st_req = 1'b1; addr = 32'h410; wdata = 32'h44;
      @(negedge clk);
      chk("t4_full_stall", {31'd0, stall_o}, 1);
      cyc();
      mem_ready = 1'b1;
      @(negedge clk);
      chk("t4_accept", {31'd0, stall_o}, 0);
      chk("t4_drain_we", {31'd0, mem_we}, 1);
      chk("t4_drain_addr", mem_addr, 32'h400);
      cyc();
      mem_ready = 1'b0;
      addr = 32'h500; wdata = 32'h55;
      @(negedge clk);
      chk("t4_still_full", {31'd0, stall_o}, 1);
      cyc();
      st_req = 1'b0;
      mem_ready = 1'b1;
      wait_empty("t4_drained");
      chk("t4_mem_last", memarr[32'h410 >> 2], 32'h44);

      // Test 5: loads hold off draining; then two back-to-back writes.
      mem_ready = 1'b0;
      store(32'h600, 32'h61);
      store(32'h604, 32'h62);
      mem_ready = 1'b1; ld_req = 1'b1; addr = 32'h700;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("t5_blocked", {31'd0, mem_we}, 0);
         chk("t5_rdata", rdata, 32'hC0DE_01C0);
         cyc();
      end
      ld_req = 1'b0;
      @(negedge clk);
      chk("t5_w0_we", {31'd0, mem_we}, 1);
      chk("t5_w0_addr", mem_addr, 32'h600);
      chk("t5_w0_data", mem_wdata, 32'h61);
      @(negedge clk);
      chk("t5_w1_we", {31'd0, mem_we}, 1);
      chk("t5_w1_addr", mem_addr, 32'h604);
      chk("t5_w1_data", mem_wdata, 32'h62);
      @(negedge clk);
      chk("t5_empty", {31'd0, empty_o}, 1);
      cyc();

      // Test 6: fence drains three entries, stall drops as the buffer empties.
      mem_ready = 1'b0;
      store(32'h300, 32'h31);
      store(32'h304, 32'h32);
      store(32'h300, 32'h33);
      fence_req = 1'b1; mem_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t6_fence_stall", {31'd0, stall_o}, 1);
      end
      @(negedge clk);
      chk("t6_release", {31'd0, stall_o}, 0);
      chk("t6_empty", {31'd0, empty_o}, 1);
      cyc();
      fence_req = 1'b0;
      chk("t6_mem_300", memarr[32'h300 >> 2], 32'h33);
      chk("t6_mem_304", memarr[32'h304 >> 2], 32'h32);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
